// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle controller and its datapath.
// master = controller (drives the control lines), slave = datapath.
interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, instr_done, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-style control unit: Moore-style state decode, with only the
// memory handshake terms (and DECODE's illegal flag) looking at inputs.
module multicycle_control_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  state_e state_q, state_d;
  logic   is_lw_q;   // lw vs sw, captured in DECODE so opcode is only looked at there
  ctl_t   ctl, ctl_o;
  logic   mr;

  assign mr = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  // State register; reset dominates every transition.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Remember whether the decoded memory op is a load.
  always_ff @(posedge clk) begin
    if (!rst_n)                  is_lw_q <= 1'b0;
    else if (state_q == S_DECODE) is_lw_q <= (bus.opcode == OP_LW);
  end

  // Next-state and control decode; everything defaults to 0 / FETCH.
  always_comb begin
    ctl     = '0;
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.pc_write  = mr;
        ctl.ir_write  = mr;
        state_d       = mr ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ctl.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_RTYPE:      state_d = S_EXECUTE;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_ADDI_EXEC;
          default: begin
            ctl.illegal_op = 1'b1;
            state_d        = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_d       = is_lw_q ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
        state_d      = mr ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctl.i_or_d     = 1'b1;
        ctl.mem_write  = 1'b1;
        ctl.instr_done = mr;
        state_d        = mr ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
        state_d       = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = 2'b01;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
        ctl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = 2'b10;
        ctl.instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_d       = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      default: begin
        ctl     = '0;
        state_d = S_FETCH;
      end
    endcase
  end

  // Hold every output (and the debug state) at 0 while reset is asserted,
  // so a stalled store never drives mem_write into the reset edge.
  assign ctl_o = rst_n ? ctl : '0;

  assign bus.pc_write      = ctl_o.pc_write;
  assign bus.pc_write_cond = ctl_o.pc_write_cond;
  assign bus.i_or_d        = ctl_o.i_or_d;
  assign bus.mem_read      = ctl_o.mem_read;
  assign bus.mem_write     = ctl_o.mem_write;
  assign bus.ir_write      = ctl_o.ir_write;
  assign bus.reg_dst       = ctl_o.reg_dst;
  assign bus.mem_to_reg    = ctl_o.mem_to_reg;
  assign bus.reg_write     = ctl_o.reg_write;
  assign bus.alu_src_a     = ctl_o.alu_src_a;
  assign bus.alu_src_b     = ctl_o.alu_src_b;
  assign bus.alu_op        = ctl_o.alu_op;
  assign bus.pc_source     = ctl_o.pc_source;
  assign bus.instr_done    = ctl_o.instr_done;
  assign bus.illegal_op    = ctl_o.illegal_op;
  assign bus.state         = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm. Each instruction is expanded
// into its expected cycle-by-cycle phase list (from latency/stall rules), the
// expected state and controls are queued, and a negedge monitor compares.
module tb_multicycle_control_fsm;

  logic clk;
  logic rst_n;
  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  typedef struct {
    logic       rst;     // drive rst_n=0 this cycle
    logic       mr;
    logic [5:0] op;
    logic [3:0] st;
    ctl_t       ctl;
  } cyc_t;

  typedef struct {
    logic [3:0] st;
    ctl_t       ctl;
  } exp_t;

  // Phase codes as the specification numbers them.
  localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4,
                 MEM_WRITE = 5, EXECUTE = 6, ALU_WB = 7, BRANCH = 8, JUMP = 9,
                 ADDI_EXEC = 10, ADDI_WB = 11;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

  cyc_t plan_q[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic bit legal(input logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
           op == OP_J || op == OP_ADDI;
  endfunction

  // Control table: what each phase asserts.
  function automatic ctl_t exp_out(input int st, input logic mr, input logic [5:0] op);
    ctl_t c = '0;
    case (st)
      FETCH:     begin c.mem_read = 1; c.alu_src_b = 2'b01; c.pc_write = mr; c.ir_write = mr; end
      DECODE:    begin c.alu_src_b = 2'b11; c.illegal_op = !legal(op); end
      MEM_ADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      MEM_READ:  begin c.mem_read = 1; c.i_or_d = 1; end
      MEM_WB:    begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
      MEM_WRITE: begin c.i_or_d = 1; c.mem_write = 1; c.instr_done = mr; end
      EXECUTE:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      ALU_WB:    begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
      BRANCH:    begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                       c.pc_source = 2'b01; c.instr_done = 1; end
      JUMP:      begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
      ADDI_EXEC: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      ADDI_WB:   begin c.reg_write = 1; c.instr_done = 1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Append one cycle; opcode is random except in DECODE, where the real one is shown.
  task automatic add(input int st, input logic mr, input logic [5:0] op, input bit is_dec);
    cyc_t c;
    c.rst = 1'b0;
    c.mr  = mr;
    c.op  = is_dec ? op : 6'($urandom_range(0, 63));
    c.st  = 4'(st);
    c.ctl = exp_out(st, mr, c.op);
    plan_q.push_back(c);
  endtask

  task automatic add_rst();
    cyc_t c;
    c.rst = 1'b1;
    c.mr  = 1'($urandom_range(0, 1));
    c.op  = 6'($urandom_range(0, 63));
    c.st  = 4'd0;
    c.ctl = '0;
    plan_q.push_back(c);
  endtask

  // Drive the planned cycles and queue their expected outputs.
  task automatic replay();
    exp_t e;
    while (plan_q.size() > 0) begin
      cyc_t c = plan_q.pop_front();
      @(posedge clk);
      #1;
      rst_n         = !c.rst;
      bus.mem_ready = c.mr;
      bus.opcode    = c.op;
      e.st  = c.st;
      e.ctl = c.ctl;
      sb_q.push_back(e);
    end
  endtask

  // One instruction from FETCH entry: f fetch stalls, m memory stalls,
  // abort_at >= 0 puts a reset into that memory-stall cycle.
  task automatic run_instr(input logic [5:0] op, input int f, input int m, input int abort_at);
    bit aborted = 0;
    int wst;
    for (int i = 0; i < f; i++) add(FETCH, 1'b0, op, 0);
    add(FETCH, 1'b1, op, 0);
    add(DECODE, 1'($urandom_range(0, 1)), op, 1);
    case (op)
      OP_R:    begin add(EXECUTE, 1'($urandom_range(0, 1)), op, 0); add(ALU_WB, 1'($urandom_range(0, 1)), op, 0); end
      OP_BEQ:  add(BRANCH, 1'($urandom_range(0, 1)), op, 0);
      OP_J:    add(JUMP, 1'($urandom_range(0, 1)), op, 0);
      OP_ADDI: begin add(ADDI_EXEC, 1'($urandom_range(0, 1)), op, 0); add(ADDI_WB, 1'($urandom_range(0, 1)), op, 0); end
      OP_LW, OP_SW: begin
        wst = (op == OP_LW) ? MEM_READ : MEM_WRITE;
        add(MEM_ADDR, 1'($urandom_range(0, 1)), op, 0);
        for (int i = 0; i < m; i++) begin
          if (i == abort_at) begin aborted = 1; break; end
          add(wst, 1'b0, op, 0);
        end
        if (aborted) add_rst();
        else begin
          add(wst, 1'b1, op, 0);
          if (op == OP_LW) add(MEM_WB, 1'($urandom_range(0, 1)), op, 0);
        end
      end
      default: ;  // illegal: back to FETCH after DECODE
    endcase
    replay();
  endtask

  // Monitor: compare every cycle against the head of the scoreboard.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      ctl_t act;
      e = sb_q.pop_front();
      act = '{bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
              bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
              bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done, bus.illegal_op};
      checks++;
      if (bus.state !== e.st) begin
        failures++;
        $display("FAIL state t=%0t got=%0d want=%0d", $time, bus.state, e.st);
      end
      checks++;
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL ctl t=%0t state=%0d got=%b want=%b", $time, bus.state, act, e.ctl);
      end
      checks++;
      if (bus.mem_write === 1'b1 && bus.reg_write === 1'b1) begin
        failures++;
        $display("FAIL wr_excl t=%0t got mem_write=1 reg_write=1 want not both", $time);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t scoreboard_left=%0d want 0", $time, sb_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    int ab;
    ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW;
    ops[3] = OP_BEQ; ops[4] = OP_J; ops[5] = OP_ADDI;
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode = 6'd0;
    repeat (2) @(posedge clk);

    // Reset state
    repeat (3) add_rst();
    replay();

    // Directed sequences
    run_instr(OP_R,    0, 0, -1);
    run_instr(OP_LW,   0, 2, -1);
    run_instr(OP_SW,   0, 0, -1);
    run_instr(OP_BEQ,  0, 0, -1);
    run_instr(OP_J,    0, 0, -1);
    run_instr(6'b111111, 0, 0, -1);
    run_instr(OP_SW,   1, 3, 2);   // reset mid MEM_WRITE stall
    run_instr(OP_ADDI, 2, 0, -1);
    run_instr(OP_LW,   0, 2, 1);   // reset mid MEM_READ stall
    run_instr(OP_SW,   0, 2, 0);   // reset on the first MEM_WRITE cycle
    run_instr(OP_LW,   3, 0, -1);

    // Random mix
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (legal(op));
      end else op = ops[$urandom_range(0, 5)];
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), ab);
      if ($urandom_range(0, 9) == 0) begin add_rst(); replay(); end
    end

    @(posedge clk);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
